// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared state encoding and index-width helper for the CNN training sequencer
package cnn_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT_CONV,
    S_INIT_FCL,
    S_FETCH,
    S_SETTLE,
    S_SM_START,
    S_SM_WAIT,
    S_SCORE,
    S_EPOCH_END,
    S_DONE
  } seq_state_t;

  // One extra bit so a counter can hold the terminal value n itself
  function automatic int idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/argmax_unit.sv
// rtl/argmax_unit.sv - combinational signed argmax over logits, lowest index wins on ties
module argmax_unit #(
  parameter int WIDTH       = 32,
  parameter int NUM_CLASSES = 10
) (
  input  logic signed [WIDTH-1:0]         logits [NUM_CLASSES],
  output logic [$clog2(NUM_CLASSES)-1:0]  max_idx
);

  localparam int CW = $clog2(NUM_CLASSES);

  logic signed [WIDTH-1:0] max_val;

  // Strict greater-than keeps the earlier index on equal values
  always_comb begin
    max_val = logits[0];
    max_idx = '0;
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (logits[i] > max_val) begin
        max_val = logits[i];
        max_idx = CW'(i);
      end
    end
  end

endmodule

// File: rtl/cnn_train_sequencer.sv
// rtl/cnn_train_sequencer.sv - control sequencer for weight init, image fetch, softmax handshake, scoring and epoch bookkeeping
module cnn_train_sequencer
  import cnn_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int NUM_CLASSES   = 10,
  parameter int CHANNELS      = 10,
  parameter int FCL_ROWS      = 1691,
  parameter int NUM_IMAGES    = 10000,
  parameter int NUM_EPOCHS    = 1,
  parameter int BATCH_SIZE    = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                skip_init,
  input  logic                                abort,
  input  logic                                train_mode,
  input  logic                                img_valid,
  output logic                                img_ready,
  input  logic [$clog2(NUM_CLASSES)-1:0]      img_label,
  input  logic signed [WIDTH-1:0]             logits [NUM_CLASSES],
  output logic                                softmax_start,
  input  logic                                softmax_busy,
  input  logic                                softmax_done,
  output logic                                conv_init_we,
  output logic [idx_w(CHANNELS)-1:0]          conv_init_idx,
  output logic                                fcl_init_we,
  output logic [idx_w(FCL_ROWS)-1:0]          fcl_init_idx,
  output logic                                grad_accum_en,
  output logic                                weight_commit,
  output logic                                pred_valid,
  output logic [$clog2(NUM_CLASSES)-1:0]      pred_class,
  output logic                                pred_correct,
  output logic [idx_w(NUM_IMAGES)-1:0]        image_index,
  output logic [idx_w(NUM_EPOCHS)-1:0]        epoch,
  output logic [idx_w(NUM_IMAGES)-1:0]        correct_count,
  output logic                                epoch_done,
  output logic [idx_w(NUM_IMAGES)-1:0]        epoch_correct,
  output logic                                busy,
  output logic                                done
);

  localparam int LW = $clog2(NUM_CLASSES);
  localparam int CW = idx_w(CHANNELS);
  localparam int FW = idx_w(FCL_ROWS);
  localparam int IW = (CW > FW) ? CW : FW;
  localparam int NW = idx_w(NUM_IMAGES);
  localparam int EW = idx_w(NUM_EPOCHS);
  localparam int BW = idx_w(BATCH_SIZE);
  localparam int SW = idx_w(SETTLE_CYCLES);

  seq_state_t    state, next_state;
  logic [IW-1:0] init_cnt;
  logic [SW-1:0] settle_cnt;
  logic [BW-1:0] batch_cnt;
  logic [LW-1:0] label_q;
  logic [LW-1:0] argmax_class;
  logic          train_q;
  logic          last_image, batch_full, last_epoch, is_correct, run_start;

  argmax_unit #(.WIDTH(WIDTH), .NUM_CLASSES(NUM_CLASSES)) u_argmax (
    .logits  (logits),
    .max_idx (argmax_class)
  );

  assign last_image = (image_index == NW'(NUM_IMAGES - 1));
  assign batch_full = (batch_cnt == BW'(BATCH_SIZE - 1));
  assign last_epoch = (epoch == EW'(NUM_EPOCHS - 1));
  assign is_correct = (argmax_class == label_q);
  assign run_start  = start && ((state == S_IDLE) || (state == S_DONE));

  assign busy          = (state != S_IDLE) && (state != S_DONE);
  assign done          = (state == S_DONE);
  assign conv_init_idx = (state == S_INIT_CONV) ? CW'(init_cnt) : '0;
  assign fcl_init_idx  = (state == S_INIT_FCL) ? FW'(init_cnt) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state    = state;
    conv_init_we  = 1'b0;
    fcl_init_we   = 1'b0;
    softmax_start = 1'b0;
    grad_accum_en = 1'b0;
    weight_commit = 1'b0;
    epoch_done    = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) next_state = skip_init ? S_FETCH : S_INIT_CONV;
      S_INIT_CONV: begin
        conv_init_we = 1'b1;
        if (init_cnt == IW'(CHANNELS - 1)) next_state = S_INIT_FCL;
      end
      S_INIT_FCL: begin
        fcl_init_we = 1'b1;
        if (init_cnt == IW'(FCL_ROWS - 1)) next_state = S_FETCH;
      end
      S_FETCH:    if (img_valid && img_ready) next_state = S_SETTLE;
      S_SETTLE:   if (settle_cnt == '0) next_state = S_SM_START;
      S_SM_START: begin
        if (!softmax_busy) begin
          softmax_start = 1'b1;
          next_state    = S_SM_WAIT;
        end
      end
      S_SM_WAIT:  if (softmax_done) next_state = S_SCORE;
      S_SCORE: begin
        grad_accum_en = train_q;
        weight_commit = train_q && (batch_full || last_image);
        next_state    = last_image ? S_EPOCH_END : S_FETCH;
      end
      S_EPOCH_END: begin
        epoch_done = 1'b1;
        next_state = last_epoch ? S_DONE : S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
    // Abort overrides everything, including pulses due this cycle
    if (abort) begin
      next_state    = S_IDLE;
      conv_init_we  = 1'b0;
      fcl_init_we   = 1'b0;
      softmax_start = 1'b0;
      grad_accum_en = 1'b0;
      weight_commit = 1'b0;
      epoch_done    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      img_ready     <= 1'b0;
      pred_valid    <= 1'b0;
      pred_class    <= '0;
      pred_correct  <= 1'b0;
      init_cnt      <= '0;
      settle_cnt    <= '0;
      batch_cnt     <= '0;
      label_q       <= '0;
      train_q       <= 1'b0;
      image_index   <= '0;
      epoch         <= '0;
      correct_count <= '0;
      epoch_correct <= '0;
    end else begin
      img_ready  <= (next_state == S_FETCH);
      pred_valid <= 1'b0;
      if (abort || run_start) begin
        init_cnt      <= '0;
        settle_cnt    <= '0;
        batch_cnt     <= '0;
        image_index   <= '0;
        epoch         <= '0;
        correct_count <= '0;
      end else begin
        case (state)
          S_INIT_CONV, S_INIT_FCL:
            init_cnt <= (next_state == state) ? init_cnt + IW'(1) : '0;
          S_FETCH: begin
            if (img_valid && img_ready) begin
              label_q    <= img_label;
              train_q    <= train_mode;
              settle_cnt <= SW'(SETTLE_CYCLES - 1);
            end
          end
          S_SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - SW'(1);
          S_SCORE: begin
            pred_valid   <= 1'b1;
            pred_class   <= argmax_class;
            pred_correct <= is_correct;
            image_index  <= image_index + NW'(1);
            if (is_correct) correct_count <= correct_count + NW'(1);
            if (train_q) batch_cnt <= (batch_full || last_image) ? '0 : batch_cnt + BW'(1);
          end
          S_EPOCH_END: begin
            epoch_correct <= correct_count;
            correct_count <= '0;
            image_index   <= '0;
            batch_cnt     <= '0;
            epoch         <= epoch + EW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnn_train_sequencer.sv
// tb/tb_cnn_train_sequencer.sv - directed, table-driven bench for cnn_train_sequencer
module tb_cnn_train_sequencer;

  logic                clk = 1'b0;
  logic                reset, start, skip_init, abort, train_mode, img_valid;
  logic                img_ready, softmax_start, softmax_busy, softmax_done;
  logic [1:0]          img_label;
  logic signed [31:0]  logits [4];
  logic                conv_init_we, fcl_init_we, grad_accum_en, weight_commit;
  logic [2:0]          conv_init_idx;
  logic [3:0]          fcl_init_idx;
  logic                pred_valid, pred_correct, epoch_done, busy, done;
  logic [1:0]          pred_class;
  logic [3:0]          image_index, correct_count, epoch_correct;
  logic [1:0]          epoch;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         l0, l1, l2, l3;
    logic [1:0] label;
    logic       train;
    logic [1:0] exp_class;
    logic       exp_correct;
    logic       exp_grad;
    logic       exp_commit;
  } vec_t;

  vec_t train_tab [5];
  vec_t infer_tab [5];

  cnn_train_sequencer #(
    .WIDTH(32), .NUM_CLASSES(4), .CHANNELS(3), .FCL_ROWS(7), .NUM_IMAGES(5),
    .NUM_EPOCHS(2), .BATCH_SIZE(2), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .skip_init(skip_init), .abort(abort),
    .train_mode(train_mode), .img_valid(img_valid), .img_ready(img_ready),
    .img_label(img_label), .logits(logits), .softmax_start(softmax_start),
    .softmax_busy(softmax_busy), .softmax_done(softmax_done),
    .conv_init_we(conv_init_we), .conv_init_idx(conv_init_idx),
    .fcl_init_we(fcl_init_we), .fcl_init_idx(fcl_init_idx),
    .grad_accum_en(grad_accum_en), .weight_commit(weight_commit),
    .pred_valid(pred_valid), .pred_class(pred_class), .pred_correct(pred_correct),
    .image_index(image_index), .epoch(epoch), .correct_count(correct_count),
    .epoch_done(epoch_done), .epoch_correct(epoch_correct), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic skip);
    start     = 1'b1;
    skip_init = skip;
    tick();
    start     = 1'b0;
    skip_init = 1'b0;
  endtask

  // mode 0: full image, 1: abort in SM_WAIT, 2: async reset in SCORE
  task automatic run_image(input vec_t v, input int busy_cycles, input int mode);
    int n;
    n = 0;
    while (!img_ready && n < 50) begin
      tick();
      n++;
    end
    check("img_ready_before_fetch", img_ready, 1);
    logits[0] = v.l0; logits[1] = v.l1; logits[2] = v.l2; logits[3] = v.l3;
    img_label  = v.label;
    train_mode = v.train;
    img_valid  = 1'b1;
    tick();
    img_valid  = 1'b0;
    train_mode = ~v.train;
    img_label  = v.label + 2'd1;
    check("img_ready_after_capture", img_ready, 0);
    tick();
    check("no_start_in_settle", softmax_start, 0);
    if (busy_cycles > 0) softmax_busy = 1'b1;
    tick();
    for (int i = 0; i < busy_cycles; i++) begin
      check("start_held_while_busy", softmax_start, 0);
      tick();
    end
    softmax_busy = 1'b0;
    #1;
    check("softmax_start_pulse", softmax_start, 1);
    tick();
    check("softmax_start_single", softmax_start, 0);
    if (mode == 1) begin
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_image_index", image_index, 0);
      check("abort_pred_valid", pred_valid, 0);
      check("abort_img_ready", img_ready, 0);
      check("abort_keeps_epoch_correct", epoch_correct, 3);
      tick();
      check("abort_stays_idle", {busy, pred_valid, softmax_start}, 0);
      return;
    end
    tick();
    softmax_done = 1'b1;
    tick();
    softmax_done = 1'b0;
    check("grad_accum_en", grad_accum_en, v.exp_grad);
    check("weight_commit", weight_commit, v.exp_commit);
    if (mode == 2) begin
      #2 reset = 1'b1;
      #1;
      check("reset_pulses", {grad_accum_en, weight_commit, busy, done, img_ready,
                             pred_valid, softmax_start, epoch_done}, 0);
      check("reset_counters", {image_index, correct_count, epoch_correct, epoch, pred_class}, 0);
      return;
    end
    tick();
    check("pred_valid", pred_valid, 1);
    check("pred_class", pred_class, v.exp_class);
    check("pred_correct", pred_correct, v.exp_correct);
  endtask

  task automatic run_epochs(input vec_t tab [5], input logic [3:0] exp_ep_correct, input int busy_first);
    for (int e = 0; e < 2; e++) begin
      for (int i = 0; i < 5; i++) begin
        run_image(tab[i], (e == 0 && i == 0) ? busy_first : 0, 0);
        if (i == 4) begin
          check("epoch_done_pulse", epoch_done, 1);
          check("correct_count_at_end", correct_count, exp_ep_correct);
          tick();
          check("epoch_done_single", epoch_done, 0);
          check("epoch_correct", epoch_correct, exp_ep_correct);
          check("epoch_advanced", epoch, e + 1);
          check("image_index_cleared", image_index, 0);
        end else begin
          check("no_epoch_done", epoch_done, 0);
          check("image_index", image_index, i + 1);
        end
      end
    end
    check("done_set", {done, busy}, 2'b10);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; skip_init = 1'b0; abort = 1'b0; train_mode = 1'b0;
    img_valid = 1'b0; img_label = '0; softmax_busy = 1'b0; softmax_done = 1'b0;
    for (int i = 0; i < 4; i++) logits[i] = '0;

    train_tab[0] = '{-5, 9, 9, 2, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
    train_tab[1] = '{-5, 9, 9, 2, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1};
    train_tab[2] = '{-5, 9, 9, 2, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0};
    train_tab[3] = '{-5, 9, 9, 2, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1};
    train_tab[4] = '{-5, 9, 9, 2, 2'd1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1};
    infer_tab[0] = '{1, 2, 3, 4, 2'd3, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0};
    infer_tab[1] = '{-1, -2, -3, -4, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    infer_tab[2] = '{-8, -3, -3, -9, 2'd2, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
    infer_tab[3] = '{7, 0, 7, 7, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
    infer_tab[4] = '{-100, 50, 60, 60, 2'd1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};

    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_state", {busy, done, img_ready, pred_valid, conv_init_we, fcl_init_we,
                          softmax_start, grad_accum_en, weight_commit, epoch_done}, 0);
    check("reset_counts", {image_index, correct_count, epoch_correct, epoch}, 0);

    start_run(1'b0);
    for (int i = 0; i < 3; i++) begin
      check("conv_init_we", conv_init_we, 1);
      check("conv_init_idx", conv_init_idx, i);
      tick();
    end
    for (int i = 0; i < 7; i++) begin
      check("fcl_init_we", {fcl_init_we, conv_init_we}, 2'b10);
      check("fcl_init_idx", fcl_init_idx, i);
      tick();
    end
    check("init_done_fetch", {img_ready, fcl_init_we}, 2'b10);

    for (int i = 0; i < 10; i++) begin
      check("fetch_hold", {img_ready, busy, conv_init_we, fcl_init_we, softmax_start,
                           grad_accum_en, weight_commit, pred_valid, epoch_done}, 9'b110000000);
      tick();
    end

    run_epochs(train_tab, 4'd5, 4);

    start_run(1'b1);
    check("restart_fetch", {img_ready, done, busy}, 3'b101);
    check("restart_keeps_epoch_correct", epoch_correct, 5);
    run_epochs(infer_tab, 4'd3, 0);

    start_run(1'b1);
    run_image(train_tab[0], 0, 0);
    run_image(train_tab[1], 0, 0);
    run_image(train_tab[2], 0, 1);

    start_run(1'b1);
    run_image(train_tab[0], 0, 2);
    tick();
    reset = 1'b0;
    tick();
    check("post_reset_idle", {busy, done, img_ready}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cnn_train_sequencer.md
Name: cnn_train_sequencer

Overview:
- Parametrised control sequencer for the CNN training loop; successor to the fixed top-level control FSM.
- Owns weight-init sweep, image fetch handshake, datapath settle timing, softmax start/done handshake, argmax scoring, mini-batch weight-commit strobes, and multi-epoch accuracy bookkeeping.
- Drives strobes and indices only; conv/maxpool/flatten/FCL/softmax datapath stays outside and is wired by the top.

Parameters:
- WIDTH, 32, logit word width (signed fixed point).
- NUM_CLASSES, 10, logit/label count, ≥2.
- CHANNELS, 10, conv kernel rows to initialise.
- FCL_ROWS, 1691, FCL weight rows to initialise, bias row included.
- NUM_IMAGES, 10000, images per epoch, ≥1.
- NUM_EPOCHS, 1, epochs per run, ≥1.
- BATCH_SIZE, 1, images per weight commit, ≥1.
- SETTLE_CYCLES, 1, combinational datapath settle cycles after image capture, ≥1.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, begin run from IDLE or DONE.
- skip_init, in, 1, sampled with start; 1 bypasses both init sweeps.
- abort, in, 1, synchronous return to IDLE.
- train_mode, in, 1, 1 = train, 0 = inference; latched per image at fetch.
- img_valid, in, 1, image and label present.
- img_ready, out, 1, sequencer accepts image.
- img_label, in, $clog2(NUM_CLASSES), class index of presented image.
- logits, in, WIDTH × NUM_CLASSES (signed, unpacked), FCL output.
- softmax_start, out, 1, one-cycle start pulse.
- softmax_busy, in, 1, softmax engine busy.
- softmax_done, in, 1, softmax result valid.
- conv_init_we, out, 1, write random kernel row.
- conv_init_idx, out, $clog2(CHANNELS)+1, kernel row index.
- fcl_init_we, out, 1, write random FCL row.
- fcl_init_idx, out, $clog2(FCL_ROWS)+1, FCL row index.
- grad_accum_en, out, 1, accumulate this image's gradient.
- weight_commit, out, 1, apply accumulated gradients.
- pred_valid, out, 1, one-cycle prediction strobe.
- pred_class, out, $clog2(NUM_CLASSES), argmax of logits.
- pred_correct, out, 1, pred_class equals the latched label.
- image_index, out, $clog2(NUM_IMAGES)+1, image index within epoch.
- epoch, out, $clog2(NUM_EPOCHS)+1, current epoch.
- correct_count, out, $clog2(NUM_IMAGES)+1, running correct count in this epoch.
- epoch_done, out, 1, one-cycle end-of-epoch pulse.
- epoch_correct, out, $clog2(NUM_IMAGES)+1, final correct count of last finished epoch.
- busy, out, 1, state is not IDLE and not DONE.
- done, out, 1, run complete; held high.

Behaviour:
- Reset: all outputs, counters and the latched label/mode are 0; state is IDLE.
- States: IDLE, INIT_CONV, INIT_FCL, FETCH, SETTLE, SM_START, SM_WAIT, SCORE, EPOCH_END, DONE.
- IDLE/DONE on start:
  - skip_init=1: go to FETCH.
  - skip_init=0: go to INIT_CONV.
  - Counters clear. done clears.
  - epoch_correct holds its value until the next EPOCH_END.
- INIT_CONV: conv_init_we=1 and conv_init_idx=0..CHANNELS-1, one row per cycle (exactly CHANNELS cycles). Then INIT_FCL.
- INIT_FCL: same pattern with fcl_init_idx=0..FCL_ROWS-1 (exactly FCL_ROWS cycles). Then FETCH.
- FETCH:
  - img_ready=1 (registered; high only in FETCH).
  - On img_valid&&img_ready: latch img_label and train_mode, load settle counter, go to SETTLE.
- SETTLE: wait SETTLE_CYCLES cycles, then SM_START.
- SM_START:
  - If softmax_busy=0: softmax_start=1 for exactly one cycle, then SM_WAIT.
  - If softmax_busy=1: hold, no pulse.
- SM_WAIT:
  - On softmax_done, go to SCORE.
  - softmax_done is ignored in every other state.
- SCORE (one cycle):
  - Argmax: signed compare; on ties the lowest index wins.
  - pred_class, pred_correct and pred_valid=1 are registered.
  - correct_count increments when the prediction is correct.
  - Latched train=1: grad_accum_en=1. weight_commit=1 in the same cycle when batch count = BATCH_SIZE-1 or this is the last image of the epoch (flushes a partial batch). batch count then clears; otherwise it increments.
  - Latched train=0: no accum/commit pulses; batch count unchanged.
  - image_index increments. If it was NUM_IMAGES-1, go to EPOCH_END; else FETCH.
- EPOCH_END (one cycle):
  - epoch_done=1 and epoch_correct ← correct_count, where correct_count includes the last image's increment. SCORE's correct_count update is visible by EPOCH_END.
  - correct_count, image_index and batch count clear; epoch increments.
  - If epoch was NUM_EPOCHS-1, go to DONE; else FETCH.
- DONE: done=1, busy=0; wait for start.
- abort (any state): next state IDLE, counters cleared. A pulse that would fire in the abort cycle is suppressed. epoch_correct is kept.
- reset mid-operation: immediate return to reset values, including pulses.
- Pulse outputs are never high for more than one consecutive cycle per event.

Decomposition:
- Shared package cnn_pkg: state typedef seq_state_t, helper function idx_w(n) = $clog2(n)+1.
- Sub-module argmax_unit (parametrised by WIDTH and NUM_CLASSES): combinational signed argmax with lowest-index tie rule, reused for the accuracy display path.

Test Plan (NUM_CLASSES=4, NUM_IMAGES=5, BATCH_SIZE=2, NUM_EPOCHS=2, CHANNELS=3, FCL_ROWS=7, SETTLE_CYCLES=2):
- start, skip_init=0 -> conv_init_we high 3 cycles with idx 0,1,2, then fcl_init_we high 7 cycles with idx 0..6, then img_ready=1.
- Train run with logits {-5,9,9,2} and label 1 on every image -> pred_class=1 (tie resolves to lower index), pred_correct=1; weight_commit after images 2, 4 and 5 of each epoch; epoch_done twice, each with epoch_correct=5; done=1.
- softmax_busy held high 4 cycles on entering SM_START -> softmax_start asserts only in the first cycle after busy falls, single pulse.
- train_mode=0, labels wrong on 2 of 5 images -> no grad_accum_en/weight_commit ever; epoch_correct=3.
- abort asserted in SM_WAIT of image 3 -> IDLE next cycle, busy=0, image_index=0, no pred_valid. reset asserted in SCORE -> all outputs 0 asynchronously.
- img_valid withheld 10 cycles in FETCH -> state holds, img_ready stays 1, no other strobes.
